// File: rtl/pc_sequenciador.sv
// Program-counter sequencer for the multi-cycle datapath.
//
// Steps a NUM_FASES-phase instruction cycle. The branch target and the branch
// decision are latched in FASE_CAPTURA, and the PC is written in FASE_ATUALIZA.
// The new PC is either PC+1 or the latched target. A taken branch whose target
// lies outside instruction memory is suppressed, and that event is flagged.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous active-low reset
//   stall         in   freeze all state for this cycle
//   branch        in   current instruction is a conditional branch
//   zero          in   ALU zero flag
//   entrada_mux   in   [31:0] branch target word address (registered by the adder stage)
//   pc            out  [31:0] current instruction word address
//   fase          out  [3:0] current phase
//   pc_valido     out  one-cycle pulse after the PC is written
//   desvio_tomado out  latched branch decision for the current instruction
//   erro_alvo     out  one-cycle pulse when a taken branch to an illegal target is suppressed
module pc_sequenciador #(
  parameter int unsigned NUM_FASES     = 10,
  parameter int unsigned FASE_CAPTURA  = 5,
  parameter int unsigned FASE_ATUALIZA = 9,
  parameter int unsigned PC_INICIAL    = 0,
  parameter int unsigned MEM_PALAVRAS  = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] entrada_mux,
  output logic [31:0] pc,
  output logic [3:0]  fase,
  output logic        pc_valido,
  output logic        desvio_tomado,
  output logic        erro_alvo
);

  logic [3:0]  fase_q, fase_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] alvo_q, alvo_d;
  logic        desvio_q, desvio_d;
  logic        pc_valido_q, pc_valido_d;
  logic        erro_q, erro_d;
  logic        alvo_legal;

  assign alvo_legal = (alvo_q < 32'(MEM_PALAVRAS));

  always_comb begin
    fase_d      = fase_q;
    pc_d        = pc_q;
    alvo_d      = alvo_q;
    desvio_d    = desvio_q;
    // The pulses default low, so a stalled cycle also drops them.
    pc_valido_d = 1'b0;
    erro_d      = 1'b0;

    if (!stall) begin
      fase_d = (fase_q == 4'(NUM_FASES - 1)) ? 4'd0 : fase_q + 4'd1;

      if (fase_q == 4'(FASE_CAPTURA)) begin
        alvo_d   = entrada_mux;
        desvio_d = branch & zero;
      end

      if (fase_q == 4'(FASE_ATUALIZA)) begin
        if (desvio_q && alvo_legal) begin
          pc_d = alvo_q;
        end else begin
          pc_d = pc_q + 32'd1;
        end
        erro_d      = desvio_q & ~alvo_legal;
        desvio_d    = 1'b0;
        pc_valido_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fase_q      <= 4'd0;
      pc_q        <= 32'(PC_INICIAL);
      alvo_q      <= 32'd0;
      desvio_q    <= 1'b0;
      pc_valido_q <= 1'b0;
      erro_q      <= 1'b0;
    end else begin
      fase_q      <= fase_d;
      pc_q        <= pc_d;
      alvo_q      <= alvo_d;
      desvio_q    <= desvio_d;
      pc_valido_q <= pc_valido_d;
      erro_q      <= erro_d;
    end
  end

  assign pc            = pc_q;
  assign fase          = fase_q;
  assign pc_valido     = pc_valido_q;
  assign desvio_tomado = desvio_q;
  assign erro_alvo     = erro_q;

endmodule

// File: tb/tb_pc_sequenciador.sv
// Self-checking bench for pc_sequenciador: reset checks, a table of whole
// instructions with hand-computed results, stall and async-reset sequences,
// and a randomized run checked cycle by cycle against an instruction-level model.
module tb_pc_sequenciador;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        branch;
  logic        zero;
  logic [31:0] entrada_mux;
  logic [31:0] pc;
  logic [3:0]  fase;
  logic        pc_valido;
  logic        desvio_tomado;
  logic        erro_alvo;

  int checks;
  int failures;

  // Reference model state, written as the instruction-level rules.
  int unsigned m_fase;
  logic [31:0] m_pc;
  logic [31:0] m_alvo;
  logic        m_desv;
  logic        m_valid;
  logic        m_err;

  typedef struct {
    logic        br;
    logic        zr;
    logic [31:0] alvo;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t tbl[8];

  pc_sequenciador dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .branch       (branch),
    .zero         (zero),
    .entrada_mux  (entrada_mux),
    .pc           (pc),
    .fase         (fase),
    .pc_valido    (pc_valido),
    .desvio_tomado(desvio_tomado),
    .erro_alvo    (erro_alvo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fase  = 0;
    m_pc    = 32'd0;
    m_alvo  = 32'd0;
    m_desv  = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock edge of the instruction cycle.
  task automatic model_edge();
    if (stall) begin
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      m_valid = (m_fase == 9);
      m_err   = 1'b0;
      if (m_fase == 5) begin
        m_alvo = entrada_mux;
        m_desv = branch & zero;
      end else if (m_fase == 9) begin
        if (m_desv && m_alvo < 256) begin
          m_pc = m_alvo;
        end else begin
          m_pc  = m_pc + 32'd1;
          m_err = m_desv;
        end
        m_desv = 1'b0;
      end
      m_fase = (m_fase + 1) % 10;
    end
  endtask

  task automatic compare_model();
    check("cyc_pc", pc, m_pc);
    check("cyc_fase", {28'd0, fase}, m_fase);
    check("cyc_pc_valido", {31'd0, pc_valido}, {31'd0, m_valid});
    check("cyc_desvio", {31'd0, desvio_tomado}, {31'd0, m_desv});
    check("cyc_erro", {31'd0, erro_alvo}, {31'd0, m_err});
  endtask

  // Inputs are set by the caller before tick; outputs compared 1 time unit after the edge.
  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
    compare_model();
  endtask

  task automatic junk_inputs();
    branch      = 1'b1;
    zero        = 1'b1;
    entrada_mux = $urandom_range(0, 255);
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b0;
    stall       = 1'b0;
    branch      = 1'b0;
    zero        = 1'b0;
    entrada_mux = 32'd0;
    model_reset();

    tbl[0] = '{br: 1'b0, zr: 1'b0, alvo: 32'h14,       exp_pc: 32'h1,   exp_err: 1'b0};
    tbl[1] = '{br: 1'b1, zr: 1'b1, alvo: 32'h14,       exp_pc: 32'h14,  exp_err: 1'b0};
    tbl[2] = '{br: 1'b1, zr: 1'b0, alvo: 32'h40,       exp_pc: 32'h15,  exp_err: 1'b0};
    tbl[3] = '{br: 1'b1, zr: 1'b1, alvo: 32'h100,      exp_pc: 32'h16,  exp_err: 1'b1};
    tbl[4] = '{br: 1'b1, zr: 1'b1, alvo: 32'hFF,       exp_pc: 32'hFF,  exp_err: 1'b0};
    tbl[5] = '{br: 1'b0, zr: 1'b1, alvo: 32'h10,       exp_pc: 32'h100, exp_err: 1'b0};
    tbl[6] = '{br: 1'b1, zr: 1'b1, alvo: 32'h3,        exp_pc: 32'h3,   exp_err: 1'b0};
    tbl[7] = '{br: 1'b1, zr: 1'b1, alvo: 32'hFFFFFFFF, exp_pc: 32'h4,   exp_err: 1'b1};

    // Reset state, held across clock edges.
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", pc, 32'd0);
    check("rst_fase", {28'd0, fase}, 32'd0);
    check("rst_pc_valido", {31'd0, pc_valido}, 32'd0);
    check("rst_desvio", {31'd0, desvio_tomado}, 32'd0);
    check("rst_erro", {31'd0, erro_alvo}, 32'd0);
    reset = 1'b1;

    // Whole instructions; off-capture phases drive a taken branch that must be ignored.
    for (int i = 0; i < 8; i++) begin
      check("tbl_start_fase", {28'd0, fase}, 32'd0);
      for (int c = 0; c < 10; c++) begin
        if (m_fase == 5) begin
          branch      = tbl[i].br;
          zero        = tbl[i].zr;
          entrada_mux = tbl[i].alvo;
        end else begin
          junk_inputs();
        end
        tick();
        if (c == 5) begin
          check("tbl_desvio_latched", {31'd0, desvio_tomado},
                {31'd0, tbl[i].br & tbl[i].zr});
        end
      end
      check("tbl_pc", pc, tbl[i].exp_pc);
      check("tbl_erro", {31'd0, erro_alvo}, {31'd0, tbl[i].exp_err});
      check("tbl_pc_valido", {31'd0, pc_valido}, 32'd1);
      check("tbl_desvio_cleared", {31'd0, desvio_tomado}, 32'd0);
    end

    // Stall held across the update phase.
    branch = 1'b0;
    zero   = 1'b0;
    repeat (9) tick();
    check("stall_pre_fase", {28'd0, fase}, 32'd9);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_fase", {28'd0, fase}, 32'd9);
      check("stall_pc", pc, 32'h4);
      check("stall_valido", {31'd0, pc_valido}, 32'd0);
    end
    stall = 1'b0;
    tick();
    check("unstall_fase", {28'd0, fase}, 32'd0);
    check("unstall_pc", pc, 32'h5);
    check("unstall_valido", {31'd0, pc_valido}, 32'd1);
    tick();
    check("unstall_valido_drop", {31'd0, pc_valido}, 32'd0);
    repeat (9) tick();

    // Async reset at phase 7 after a taken capture.
    repeat (5) tick();
    branch      = 1'b1;
    zero        = 1'b1;
    entrada_mux = 32'h30;
    tick();
    check("arst_captured", {31'd0, desvio_tomado}, 32'd1);
    branch = 1'b0;
    zero   = 1'b0;
    tick();
    check("arst_pre_fase", {28'd0, fase}, 32'd7);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("arst_pc", pc, 32'd0);
    check("arst_fase", {28'd0, fase}, 32'd0);
    check("arst_desvio", {31'd0, desvio_tomado}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (10) tick();
    check("arst_next_pc", pc, 32'd1);

    // Randomized run against the model.
    for (int n = 0; n < 2000; n++) begin
      stall  = ($urandom_range(0, 3) == 0);
      branch = $urandom_range(0, 1);
      zero   = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        entrada_mux = $urandom;
      end else begin
        entrada_mux = $urandom_range(0, 300);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequenciador.md
Name: pc_sequenciador

Overview:
Program-counter sequencer for the multi-cycle datapath. It consumes the registered branch target (PC + imm/4) produced by the branch-target adder stage, together with the control unit's branch flag and the ALU's zero flag. It selects the next PC (PC+1 or the branch target), owns the 10-phase instruction cycle counter, and drives the PC and phase to the rest of the datapath.

Parameters:
NUM_FASES, 10, number of phases per instruction (0..NUM_FASES-1).
FASE_CAPTURA, 5, phase in which the target and the branch decision are latched. The adder registers its sum at phase 4, so the sum is stable from phase 5.
FASE_ATUALIZA, 9, phase in which PC is written.
PC_INICIAL, 0, PC value after reset.
MEM_PALAVRAS, 256, instruction memory depth in words. A target >= MEM_PALAVRAS is illegal.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stall  input  1  high = freeze all state this cycle.
branch  input  1  control: current instruction is a conditional branch.
zero  input  1  ALU zero flag.
entrada_mux  input  32  branch target word address from the adder stage.
pc  output  32  current instruction word address.
fase  output  4  current phase, 0..NUM_FASES-1.
pc_valido  output  1  one-cycle pulse: new PC just written.
desvio_tomado  output  1  latched branch decision for the current instruction.
erro_alvo  output  1  one-cycle pulse: taken branch to an illegal target was suppressed.

Behaviour:
- Reset (reset==0, async, regardless of clock):
  - pc=PC_INICIAL, fase=0, desvio_tomado=0, pc_valido=0, erro_alvo=0.
  - Internal alvo register=0.
  - Takes effect immediately, even mid-instruction; any partially latched decision is discarded.
- Phase counter:
  - On each rising edge with stall==0: fase <= (fase==NUM_FASES-1) ? 0 : fase+1.
  - With stall==1: fase, pc, alvo and desvio_tomado hold their values.
  - pc_valido and erro_alvo are forced to 0 during stall.
- Capture (edge where fase==FASE_CAPTURA and stall==0):
  - alvo <= entrada_mux.
  - desvio_tomado <= branch & zero.
  - In any other phase, entrada_mux, branch and zero are ignored.
- Update (edge where fase==FASE_ATUALIZA and stall==0):
  - If desvio_tomado==1 and alvo < MEM_PALAVRAS: pc <= alvo.
  - If desvio_tomado==1 and alvo >= MEM_PALAVRAS: pc <= pc+1 and erro_alvo <= 1 for one cycle.
  - Otherwise: pc <= pc+1.
  - pc+1 is a 32-bit modulo add (0xFFFFFFFF -> 0). No wrap to MEM_PALAVRAS.
  - On the same edge, desvio_tomado <= 0 (cleared for the next instruction).
- pc_valido:
  - Registered; equals 1 during the cycle following the update edge (i.e. while fase==0 after an update).
  - Stays 0 in the first fase==0 after reset.
- Stall timing:
  - Stall held across an update phase defers the update until the first non-stalled edge in that phase.
  - Exactly one update occurs per instruction.
- Simultaneous events: reset dominates stall, and stall dominates capture/update.
- Timing: all outputs are registered, with no combinational path from inputs to outputs.
- Latency: branch decision to new PC is 4 edges (capture at phase 5, write at phase 9), in the absence of stalls.

Test Plan:
- Reset then 10 clocks, branch=0 -> fase cycles 0..9,0; pc 0->1 at the 10th edge; pc_valido high exactly one cycle in the following phase 0.
- pc=3, branch=1, zero=1, entrada_mux=0x14 at phase 5 -> desvio_tomado=1 from phase 6; pc=0x14 after the phase-9 edge; desvio_tomado=0 afterwards.
- branch=1, zero=0, entrada_mux=0x40 -> pc increments by 1. Change entrada_mux to 0x80 in phase 7 with branch=1, zero=1 -> no effect (captured only in phase 5).
- Taken branch with entrada_mux=0x100 (MEM_PALAVRAS=256) -> pc=old+1; erro_alvo pulses for one cycle.
- Stall asserted at fase=9 for 3 cycles -> fase and pc frozen, no pc_valido. Release stall -> single update, then fase=0 with pc_valido=1.
- Drive reset low asynchronously at fase=7 after a taken-branch capture -> immediate pc=0, fase=0, desvio_tomado=0. After release, the next update yields pc=1.
